// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and
// default line/address widths.
package mem_arb_pkg;

  localparam int LINE_W_DEF  = 128;
  localparam int LADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_I  = 2'd1,
    RD_D  = 2'd2,
    WR_WB = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_wb_buffer.sv
// One-entry D-cache write-back buffer. A capture may coincide with a drain, so
// a new line can land in the same cycle the old one is written to memory.
module arb_wb_buffer
  import mem_arb_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int LADDR_W = LADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [LADDR_W-1:0] waddr,
  input  logic [LINE_W-1:0]  wline,
  input  logic               drain,
  input  logic [LADDR_W-1:0] cmp_addr,
  output logic               full,
  output logic [LADDR_W-1:0] addr,
  output logic [LINE_W-1:0]  line,
  output logic               match
);

  logic capture;

  assign capture = we && (!full || drain);
  assign match   = full && (addr == cmp_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      addr <= '0;
      line <= '0;
    end else if (capture) begin
      full <= 1'b1;
      addr <= waddr;
      line <= wline;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // The D-cache is expected to watch Arb_wb_full; a lost write-back is a bug upstream.
  always @(posedge clk) begin
    if (!rst && we && full && !drain)
      $error("arb_wb_buffer: write-back to 0x%0h dropped, buffer full", waddr);
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-refill, D-refill and buffered D write-backs onto one line-wide
// memory. Define ARB_RR_EN for round-robin between I and D refills on a tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int LADDR_W = LADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Ic_mem_req,
  input  logic [LADDR_W-1:0] Ic_mem_addr,
  output logic [LINE_W-1:0]  F_mem_inst,
  output logic               F_mem_valid,
  input  logic               Dc_mem_req,
  input  logic [LADDR_W-1:0] Dc_mem_addr,
  output logic [LINE_W-1:0]  MEM_data_line,
  output logic               MEM_mem_valid,
  input  logic               Dc_wb_we,
  input  logic [LADDR_W-1:0] Dc_wb_addr,
  input  logic [LINE_W-1:0]  Dc_wb_wline,
  output logic               Arb_wb_full,
  output logic               Arb_mem_req,
  output logic               Arb_mem_we,
  output logic [LADDR_W-1:0] Arb_mem_addr,
  output logic [LINE_W-1:0]  Arb_mem_wline,
  input  logic [LINE_W-1:0]  Arb_mem_rline,
  input  logic               Arb_mem_valid
);

  arb_state_t         state;
  arb_state_t         grant;
  logic               mask_i, mask_d;
  logic               req_i, req_d;
  logic               tie_i;
  logic               drain;
  logic               wb_full, wb_match;
  logic [LADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0]  wb_line;

  arb_wb_buffer #(.LINE_W(LINE_W), .LADDR_W(LADDR_W)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .we       (Dc_wb_we),
    .waddr    (Dc_wb_addr),
    .wline    (Dc_wb_wline),
    .drain    (drain),
    .cmp_addr (Dc_mem_addr),
    .full     (wb_full),
    .addr     (wb_addr),
    .line     (wb_line),
    .match    (wb_match)
  );

  assign drain = (state == WR_WB) && Arb_mem_valid;
  assign req_i = Ic_mem_req && !mask_i;
  assign req_d = Dc_mem_req && !mask_d;

`ifdef ARB_RR_EN
  logic rr_i;

  // Points at I after a D refill completes and back at D after an I refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_i <= 1'b0;
    else if (Arb_mem_valid && state == RD_D)
      rr_i <= 1'b1;
    else if (Arb_mem_valid && state == RD_I)
      rr_i <= 1'b0;
  end

  assign tie_i = rr_i;
`else
  assign tie_i = 1'b0;
`endif

  // A refill hitting the buffered line must see the write land first.
  always_comb begin
    grant = IDLE;
    if (wb_full && req_d && wb_match)
      grant = WR_WB;
    else if (req_d && req_i)
      grant = tie_i ? RD_I : RD_D;
    else if (req_d)
      grant = RD_D;
    else if (req_i)
      grant = RD_I;
    else if (wb_full)
      grant = WR_WB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mask_i        <= 1'b0;
      mask_d        <= 1'b0;
      Arb_mem_req   <= 1'b0;
      Arb_mem_we    <= 1'b0;
      Arb_mem_addr  <= '0;
      Arb_mem_wline <= '0;
    end else begin
      case (state)
        IDLE: begin
          mask_i <= 1'b0;
          mask_d <= 1'b0;
          state  <= grant;
          if (grant != IDLE) begin
            Arb_mem_req   <= 1'b1;
            Arb_mem_we    <= (grant == WR_WB);
            Arb_mem_addr  <= (grant == WR_WB) ? wb_addr :
                             (grant == RD_D)  ? Dc_mem_addr : Ic_mem_addr;
            Arb_mem_wline <= (grant == WR_WB) ? wb_line : '0;
          end
        end
        default: begin
          if (Arb_mem_valid) begin
            state         <= IDLE;
            mask_i        <= (state == RD_I);
            mask_d        <= (state == RD_D);
            Arb_mem_req   <= 1'b0;
            Arb_mem_we    <= 1'b0;
            Arb_mem_addr  <= '0;
            Arb_mem_wline <= '0;
          end
        end
      endcase
    end
  end

  assign F_mem_valid   = (state == RD_I) && Arb_mem_valid;
  assign MEM_mem_valid = (state == RD_D) && Arb_mem_valid;
  assign F_mem_inst    = F_mem_valid   ? Arb_mem_rline : '0;
  assign MEM_data_line = MEM_mem_valid ? Arb_mem_rline : '0;
  assign Arb_wb_full   = wb_full;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level
// model; a memory responder with variable latency lives in the bench.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 10;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Ic_mem_req = 1'b0, Dc_mem_req = 1'b0, Dc_wb_we = 1'b0, Arb_mem_valid = 1'b0;
  logic [AW-1:0] Ic_mem_addr = '0, Dc_mem_addr = '0, Dc_wb_addr = '0;
  logic [LW-1:0] Dc_wb_wline = '0, Arb_mem_rline = '0;
  logic [LW-1:0] F_mem_inst, MEM_data_line, Arb_mem_wline;
  logic          F_mem_valid, MEM_mem_valid, Arb_wb_full, Arb_mem_req, Arb_mem_we;
  logic [AW-1:0] Arb_mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LW), .LADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .Ic_mem_req(Ic_mem_req), .Ic_mem_addr(Ic_mem_addr),
    .F_mem_inst(F_mem_inst), .F_mem_valid(F_mem_valid),
    .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
    .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
    .Arb_wb_full(Arb_wb_full),
    .Arb_mem_req(Arb_mem_req), .Arb_mem_we(Arb_mem_we),
    .Arb_mem_addr(Arb_mem_addr), .Arb_mem_wline(Arb_mem_wline),
    .Arb_mem_rline(Arb_mem_rline), .Arb_mem_valid(Arb_mem_valid)
  );

  logic [LW-1:0] mem [0:1023];
  int total = 0, bad = 0, cyc = 0;

  // memory responder and requester controls
  bit mbusy; int mcnt; int fixed_lat = 1; bit spur_en = 0; bit rand_mode = 0; bit force_linger = 0;
  int i_on = 0, d_on = 0; logic [AW-1:0] i_addr = '0, d_addr = '0;
  bit wb_pend = 0; logic [AW-1:0] wb_a = '0; logic [LW-1:0] wb_l = '0;

  // transaction model: kind 0 none, 1 I read, 2 D read, 3 write-back
  int m_cur; logic [AW-1:0] m_addr; logic [LW-1:0] m_wline;
  bit m_mi, m_md, m_rr_i, m_full; logic [AW-1:0] m_baddr; logic [LW-1:0] m_bline;

  int lg_kind[$]; logic [AW-1:0] lg_addr[$]; logic [LW-1:0] lg_line[$]; int lg_cyc[$];

  function automatic logic [LW-1:0] init_line(input int a);
    return {4{16'(a), 16'(a * 37 + 5)}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  task automatic log_is(input string nm, input int idx, input int kind, input int addr);
    int k, a;
    k = (idx < lg_kind.size()) ? lg_kind[idx] : -1;
    a = (idx < lg_kind.size()) ? int'(lg_addr[idx]) : -1;
    chk({nm, "_kind"}, LW'(k), LW'(kind));
    chk({nm, "_addr"}, LW'(a), LW'(addr));
  endtask

  task automatic clear_log();
    lg_kind.delete(); lg_addr.delete(); lg_line.delete(); lg_cyc.delete();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_req"},   LW'(Arb_mem_req), '0);
    chk({nm, "_we"},    LW'(Arb_mem_we), '0);
    chk({nm, "_addr"},  LW'(Arb_mem_addr), '0);
    chk({nm, "_wline"}, Arb_mem_wline, '0);
    chk({nm, "_fv"},    LW'(F_mem_valid), '0);
    chk({nm, "_fi"},    F_mem_inst, '0);
    chk({nm, "_mv"},    LW'(MEM_mem_valid), '0);
    chk({nm, "_md"},    MEM_data_line, '0);
    chk({nm, "_full"},  LW'(Arb_wb_full), '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string nm);
    @(posedge clk); #2;
    rst = 1'b1;
    Ic_mem_req = 0; Dc_mem_req = 0; Dc_wb_we = 0; Arb_mem_valid = 0; Arb_mem_rline = '0;
    #1;
    check_zero(nm);
    m_cur = 0; m_addr = '0; m_wline = '0; m_mi = 0; m_md = 0; m_rr_i = 0;
    m_full = 0; m_baddr = '0; m_bline = '0;
    mbusy = 0; mcnt = 0; i_on = 0; d_on = 0; wb_pend = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle();
    bit mv, done, drain, cap, ir, dr, idone, ddone;
    logic [LW-1:0] ml;
    int g;
    @(posedge clk); #1;
    cyc++;
    mv = 0; ml = '0;
    if (Arb_mem_req) begin
      if (!mbusy) begin
        mbusy = 1;
        mcnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (mcnt == 0) begin
        mv = 1; mbusy = 0;
        if (Arb_mem_we) mem[Arb_mem_addr] = Arb_mem_wline;
        else ml = mem[Arb_mem_addr];
      end else mcnt--;
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      mv = 1; ml = {4{$urandom}};
    end
    Arb_mem_valid = mv; Arb_mem_rline = ml;
    Ic_mem_req = (i_on != 0); Ic_mem_addr = i_addr;
    Dc_mem_req = (d_on != 0); Dc_mem_addr = d_addr;
    Dc_wb_we = 0;
    if (wb_pend && (!m_full || (m_cur == 3 && mv))) begin
      Dc_wb_we = 1; Dc_wb_addr = wb_a; Dc_wb_wline = wb_l; wb_pend = 0;
    end
    @(negedge clk);

    chk("req",   LW'(Arb_mem_req), LW'(m_cur != 0));
    chk("we",    LW'(Arb_mem_we), LW'(m_cur == 3));
    chk("addr",  LW'(Arb_mem_addr), (m_cur != 0) ? LW'(m_addr) : '0);
    chk("wline", Arb_mem_wline, (m_cur == 3) ? m_wline : '0);
    chk("fv",    LW'(F_mem_valid), LW'(m_cur == 1 && mv));
    chk("fi",    F_mem_inst, (m_cur == 1 && mv) ? mem[m_addr] : '0);
    chk("mv",    LW'(MEM_mem_valid), LW'(m_cur == 2 && mv));
    chk("md",    MEM_data_line, (m_cur == 2 && mv) ? mem[m_addr] : '0);
    chk("full",  LW'(Arb_wb_full), LW'(m_full));

    if (F_mem_valid) begin
      lg_kind.push_back(1); lg_addr.push_back(Arb_mem_addr); lg_line.push_back(F_mem_inst); lg_cyc.push_back(cyc);
    end
    if (MEM_mem_valid) begin
      lg_kind.push_back(2); lg_addr.push_back(Arb_mem_addr); lg_line.push_back(MEM_data_line); lg_cyc.push_back(cyc);
    end
    if (Arb_mem_req && Arb_mem_we && Arb_mem_valid) begin
      lg_kind.push_back(3); lg_addr.push_back(Arb_mem_addr); lg_line.push_back(Arb_mem_wline); lg_cyc.push_back(cyc);
    end

    done  = (m_cur != 0) && mv;
    idone = done && m_cur == 1;
    ddone = done && m_cur == 2;
    drain = done && m_cur == 3;
    cap   = Dc_wb_we && (!m_full || drain);
    if (done) begin
      m_mi = (m_cur == 1); m_md = (m_cur == 2);
      if (m_cur == 1) m_rr_i = 0;
      if (m_cur == 2) m_rr_i = 1;
      m_cur = 0;
    end else if (m_cur == 0) begin
      ir = Ic_mem_req && !m_mi;
      dr = Dc_mem_req && !m_md;
      g = 0;
      if (m_full && dr && Dc_mem_addr == m_baddr) g = 3;
      else if (dr && ir) g = (RR && m_rr_i) ? 1 : 2;
      else if (dr) g = 2;
      else if (ir) g = 1;
      else if (m_full) g = 3;
      m_mi = 0; m_md = 0;
      m_cur = g;
      if (g == 1) m_addr = Ic_mem_addr;
      if (g == 2) m_addr = Dc_mem_addr;
      if (g == 3) begin m_addr = m_baddr; m_wline = m_bline; end
    end
    if (drain) m_full = 0;
    if (cap) begin m_full = 1; m_baddr = Dc_wb_addr; m_bline = Dc_wb_wline; end

    if (i_on == 2) i_on = 0;
    else if (i_on == 1 && idone) i_on = (force_linger || (rand_mode && $urandom_range(0, 1) == 1)) ? 2 : 0;
    if (d_on == 2) d_on = 0;
    else if (d_on == 1 && ddone) d_on = (force_linger || (rand_mode && $urandom_range(0, 1) == 1)) ? 2 : 0;
    if (rand_mode) begin
      if (i_on == 0 && $urandom_range(0, 3) == 0) begin i_on = 1; i_addr = AW'($urandom_range(0, 15)); end
      if (d_on == 0 && $urandom_range(0, 3) == 0) begin d_on = 1; d_addr = AW'($urandom_range(0, 15)); end
      if (!wb_pend && $urandom_range(0, 5) == 0) begin
        wb_pend = 1; wb_a = AW'($urandom_range(0, 15)); wb_l = {4{$urandom}};
      end
    end
  endtask

  initial begin
    int t1_start, lat_got, k1, k2;
    for (int a = 0; a < 1024; a++) mem[a] = init_line(a);

    #1;
    check_zero("rst0");
    do_reset("rst1");

    // single I refill, latency 2, request lingers one cycle after completion
    fixed_lat = 2; force_linger = 1; clear_log();
    i_addr = AW'(12'h012); i_on = 1; t1_start = cyc + 1;
    repeat (10) cycle();
    chk("t1_n", LW'(lg_kind.size()), LW'(1));
    log_is("t1_0", 0, 1, 'h012);
    chk("t1_line", (lg_line.size() > 0) ? lg_line[0] : '0, init_line('h012));
    lat_got = (lg_cyc.size() > 0) ? lg_cyc[0] - t1_start : -1;
    chk("t1_lat", LW'(lat_got), LW'(3));

    // simultaneous I and D: D first after a fresh I completion
    fixed_lat = 1; force_linger = 0; clear_log();
    i_addr = AW'(12'h005); i_on = 1; d_addr = AW'(12'h100); d_on = 1;
    repeat (12) cycle();
    chk("t2_n", LW'(lg_kind.size()), LW'(2));
    log_is("t2_0", 0, 2, 'h100);
    log_is("t2_1", 1, 1, 'h005);

    // lone D refill, then another tie: round-robin now favours I
    clear_log();
    d_addr = AW'(12'h101); d_on = 1;
    repeat (6) cycle();
    i_addr = AW'(12'h006); i_on = 1; d_addr = AW'(12'h102); d_on = 1;
    repeat (12) cycle();
    k1 = RR ? 1 : 2; k2 = RR ? 2 : 1;
    chk("t2b_n", LW'(lg_kind.size()), LW'(3));
    log_is("t2b_0", 0, 2, 'h101);
    log_is("t2b_1", 1, k1, RR ? 'h006 : 'h102);
    log_is("t2b_2", 2, k2, RR ? 'h102 : 'h006);

    // write-back alone
    clear_log();
    wb_a = AW'(12'h040); wb_l = {16{8'hA5}}; wb_pend = 1;
    cycle(); cycle();
    chk("t3_full_set", LW'(Arb_wb_full), LW'(1));
    repeat (8) cycle();
    chk("t3_n", LW'(lg_kind.size()), LW'(1));
    log_is("t3_0", 0, 3, 'h040);
    chk("t3_wline", (lg_line.size() > 0) ? lg_line[0] : '0, {16{8'hA5}});
    chk("t3_full_clr", LW'(Arb_wb_full), LW'(0));

    // RAW: buffered 0x040 must be written before the D refill of 0x040
    clear_log();
    wb_a = AW'(12'h040); wb_l = {16{8'h5A}}; wb_pend = 1;
    cycle();
    i_addr = AW'(12'h077); i_on = 1; d_addr = AW'(12'h040); d_on = 1;
    repeat (16) cycle();
    chk("t4_n", LW'(lg_kind.size()), LW'(3));
    log_is("t4_0", 0, 3, 'h040);
    log_is("t4_1", 1, 2, 'h040);
    log_is("t4_2", 2, 1, 'h077);
    chk("t4_raw", (lg_line.size() > 1) ? lg_line[1] : '0, {16{8'h5A}});

    // non-matching D refill goes ahead of the buffered write
    clear_log();
    wb_a = AW'(12'h040); wb_l = {16{8'h3C}}; wb_pend = 1;
    cycle();
    d_addr = AW'(12'h041); d_on = 1;
    repeat (12) cycle();
    chk("t5_n", LW'(lg_kind.size()), LW'(2));
    log_is("t5_0", 0, 2, 'h041);
    log_is("t5_1", 1, 3, 'h040);

    // reset during an outstanding D refill with a full buffer
    fixed_lat = 3;
    d_addr = AW'(12'h123); d_on = 1;
    wb_a = AW'(12'h200); wb_l = {16{8'hEE}}; wb_pend = 1;
    cycle(); cycle();
    chk("t6_busy", LW'(Arb_mem_req), LW'(1));
    chk("t6_full", LW'(Arb_wb_full), LW'(1));
    do_reset("t6_rst");
    fixed_lat = 1; clear_log();
    i_addr = AW'(12'h033); i_on = 1;
    repeat (8) cycle();
    chk("t6_n", LW'(lg_kind.size()), LW'(1));
    log_is("t6_0", 0, 1, 'h033);

    // randomised traffic with variable latency and stray completion pulses
    fixed_lat = -1; spur_en = 1; rand_mode = 1;
    repeat (4000) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
